// File: rtl/aes_pkg.sv
// Shared definitions for the AES round scheduler: one-hot state codes and
// default round count / key-generation timeout.
package aes_pkg;
  localparam int         AES_NUM_ROUNDS  = 2;
  localparam logic [7:0] AES_KEY_TIMEOUT = 8'd255;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LOAD   = 5'b00010,
    ST_KEYGEN = 5'b00100,
    ST_WAIT   = 5'b01000,
    ST_FINISH = 5'b10000
  } aes_state_e;
endpackage

// File: rtl/aes_round_sched_if.sv
// Host / round-controller / key-generator handshake bundle for aes_round_sched.
// slave is the scheduler side, master is whoever drives the requests.
interface aes_round_sched_if;
  logic       start;
  logic       abort;
  logic       fsm_add_key;
  logic       fsm_result;
  logic       key_gen_ack;
  logic       load;
  logic       key_gen_req;
  logic       key_generation_done;
  logic       final_round;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start, abort, fsm_add_key, fsm_result, key_gen_ack,
    output load, key_gen_req, key_generation_done, final_round,
           round_idx, busy, done, err
  );
  modport master (
    output start, abort, fsm_add_key, fsm_result, key_gen_ack,
    input  load, key_gen_req, key_generation_done, final_round,
           round_idx, busy, done, err
  );
endinterface

// File: rtl/aes_rise_det.sv
// 1-bit rising-edge detector; history flop runs every cycle so a level held
// across state changes is only ever reported once.
module aes_rise_det (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences load, per-round key requests and round
// hand-offs to the round controller, with key-generation watchdog and abort.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS  = AES_NUM_ROUNDS,
  parameter logic [7:0] KEY_TIMEOUT = AES_KEY_TIMEOUT
) (
  input  logic        clk,
  input  logic        nrst,
  aes_round_sched_if.slave bus
);
  localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

  aes_state_e state_q, state_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic [7:0] wdog_q, wdog_d;
  logic       load_q, load_d, req_q, req_d, kgd_q, kgd_d, fin_q, fin_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       add_rise;
  logic [7:0] wdog_inc;

  aes_rise_det u_rise (.clk(clk), .nrst(nrst), .d(bus.fsm_add_key), .rise(add_rise));

  assign wdog_inc = wdog_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    wdog_d      = wdog_q;
    req_d       = req_q;
    kgd_d       = kgd_q;
    load_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    // abort wins over every other event in the same cycle
    if (bus.abort) begin
      state_d     = ST_IDLE;
      round_idx_d = '0;
      wdog_d      = '0;
      req_d       = 1'b0;
      kgd_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          state_d     = ST_LOAD;
          round_idx_d = 4'd1;
          load_d      = 1'b1;
        end
        ST_LOAD: begin
          state_d = ST_KEYGEN;
          req_d   = 1'b1;
          wdog_d  = '0;
        end
        ST_KEYGEN: if (bus.key_gen_ack) begin
          req_d   = 1'b0;
          kgd_d   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == KEY_TIMEOUT) begin
            err_d       = 1'b1;
            state_d     = ST_IDLE;
            req_d       = 1'b0;
            round_idx_d = '0;
            wdog_d      = '0;
          end
        end
        ST_WAIT: if (add_rise) begin
          kgd_d = 1'b0;
          if (fin_q) state_d = ST_FINISH;
          else begin
            round_idx_d = round_idx_q + 4'd1;
            state_d     = ST_KEYGEN;
            req_d       = 1'b1;
            wdog_d      = '0;
          end
        end
        ST_FINISH: if (bus.fsm_result) begin
          done_d      = 1'b1;
          state_d     = ST_IDLE;
          round_idx_d = '0;
        end
        default: begin
          state_d     = ST_IDLE;
          round_idx_d = '0;
          wdog_d      = '0;
          req_d       = 1'b0;
          kgd_d       = 1'b0;
        end
      endcase
    end
    fin_d  = (state_d != ST_IDLE) && (round_idx_d == ROUND_LAST);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      round_idx_q <= '0;
      wdog_q      <= '0;
      load_q      <= 1'b0;
      req_q       <= 1'b0;
      kgd_q       <= 1'b0;
      fin_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      wdog_q      <= wdog_d;
      load_q      <= load_d;
      req_q       <= req_d;
      kgd_q       <= kgd_d;
      fin_q       <= fin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.load                = load_q;
  assign bus.key_gen_req         = req_q;
  assign bus.key_generation_done = kgd_q;
  assign bus.final_round         = fin_q;
  assign bus.round_idx           = round_idx_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.err                 = err_q;
endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 The module SHALL have parameter NUM_ROUNDS, default 2, meaning the number of cipher rounds after the round-0 key addition (legal range 1..15).
REQ-002 The module SHALL have parameter KEY_TIMEOUT, default 8'd255, meaning the maximum number of cycles to wait for key_gen_ack (legal range 1..255).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: host request to begin one encryption; sampled only in IDLE.
REQ-006 Port abort, input, 1 bit: synchronous cancel; valid in any state.
REQ-007 Port fsm_add_key, input, 1 bit: round-controller add-key strobe (level).
REQ-008 Port fsm_result, input, 1 bit: round-controller result-valid (level).
REQ-009 Port key_gen_ack, input, 1 bit: key generator has produced the requested round key.
REQ-010 Port load, output, 1 bit: one-cycle start pulse to the round controller.
REQ-011 Port key_gen_req, output, 1 bit: request for the next round key; held until acknowledged.
REQ-012 Port key_generation_done, output, 1 bit: current round key is ready.
REQ-013 Port final_round, output, 1 bit: the current round is the last round.
REQ-014 Port round_idx, output, 4 bits: current round number.
REQ-015 Port busy, output, 1 bit: an operation is in progress.
REQ-016 Port done, output, 1 bit: one-cycle completion pulse.
REQ-017 Port err, output, 1 bit: one-cycle key-generation timeout pulse.

Function
REQ-018 The module SHALL implement the states IDLE, LOAD, KEYGEN, WAIT_ROUND and FINISH as a one-hot registered state machine with registered outputs.
REQ-019 IDLE: on start=1 the module SHALL go to LOAD and set round_idx=1; start is ignored in all other states.
REQ-020 LOAD: load=1 for exactly one cycle, then the module SHALL go to KEYGEN.
REQ-021 KEYGEN: key_gen_req=1 until key_gen_ack=1 is sampled; on ack the module SHALL deassert key_gen_req, set key_generation_done=1 and go to WAIT_ROUND.
REQ-022 Watchdog: an 8-bit counter SHALL clear on KEYGEN entry and increment each KEYGEN cycle without ack; on reaching KEY_TIMEOUT the module SHALL pulse err for one cycle and go to IDLE.
REQ-023 final_round SHALL equal (round_idx == NUM_ROUNDS) in every state other than IDLE, and SHALL be 0 in IDLE.
REQ-024 WAIT_ROUND: on a fsm_add_key 0->1 edge the module SHALL clear key_generation_done; if final_round=1 it SHALL go to FINISH, otherwise it SHALL increment round_idx and go to KEYGEN.
REQ-025 fsm_add_key held high SHALL count as one edge only; the module SHALL never count the same edge twice.
REQ-026 FINISH: on fsm_result=1 the module SHALL pulse done for one cycle and go to IDLE with round_idx=0.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 abort=1 SHALL force IDLE on the next edge with all outputs cleared and no done or err pulse; abort has priority over any simultaneous ack, edge or fsm_result.
REQ-029 round_idx SHALL never exceed NUM_ROUNDS and SHALL never wrap.

Reset
REQ-030 While nrst=0 the module SHALL be in IDLE with round_idx=0, the watchdog counter at 0, the edge-detector history at 0, and every output at 0.
REQ-031 Reset SHALL be honoured in any state, including mid-operation; after release the module SHALL wait for a new start.

Structure
REQ-032 State encodings and the NUM_ROUNDS and KEY_TIMEOUT defaults SHALL live in the shared package aes_pkg.
REQ-033 Rising-edge detection of fsm_add_key SHALL be a sub-module named aes_rise_det (1-bit registered edge detector).

Verification
REQ-034 NUM_ROUNDS=2; start; ack 3 cycles after each request; two add_key edges; then fsm_result -> load pulse 1 cycle after start; round_idx sequence 1 then 2; final_round=1 only at round 2; one done pulse.
REQ-035 KEY_TIMEOUT=4; no ack -> err pulses after 4 KEYGEN cycles; busy=0 on the next cycle; no done.
REQ-036 Abort asserted in the same cycle as key_gen_ack -> IDLE; key_generation_done stays 0; no done.
REQ-037 fsm_add_key held high for 5 cycles -> round_idx increments by exactly 1.
REQ-038 nrst pulsed low in WAIT_ROUND at round 1 -> all outputs 0; a subsequent start runs the full sequence cleanly.
REQ-039 start pulsed while busy=1 -> no effect; exactly one done pulse.
